// File: rtl/defender_input_pkg.sv
// Shared definitions for the Defender input controller: button bit map,
// PS/2 scancodes, held-key slots and the coin/start sequencer states.
package defender_input_pkg;

    localparam int BTN_ADVANCE     = 0;
    localparam int BTN_AUTO_UP     = 1;
    localparam int BTN_HS_RESET    = 2;
    localparam int BTN_COIN        = 3;
    localparam int BTN_ONE_PLAYER  = 4;
    localparam int BTN_TWO_PLAYERS = 5;
    localparam int BTN_FIRE        = 6;
    localparam int BTN_THRUST      = 7;
    localparam int BTN_SMART_BOMB  = 8;
    localparam int BTN_HYPERSPACE  = 9;
    localparam int BTN_REVERSE     = 10;
    localparam int BTN_DOWN        = 11;
    localparam int BTN_UP          = 12;
    localparam int BTN_W           = 13;

    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_U      = 8'h3C;
    localparam logic [7:0] SC_H      = 8'h33;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_6      = 8'h36;

    localparam int KEY_UP = 0, KEY_DOWN = 1, KEY_LEFT = 2, KEY_RIGHT = 3;
    localparam int KEY_LSHIFT = 4, KEY_RSHIFT = 5, KEY_SPACE = 6, KEY_F1 = 7;
    localparam int KEY_F2 = 8, KEY_CTRL = 9, KEY_W = 10, KEY_A = 11;
    localparam int KEY_U = 12, KEY_H = 13, KEY_1 = 14, KEY_2 = 15;
    localparam int KEY_5 = 16, KEY_6 = 17;
    localparam int NUM_KEYS  = 18;
    localparam int KEY_IDX_W = 5;
    localparam logic [KEY_IDX_W-1:0] KEY_NONE = 5'd31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COIN    = 3'd1,
        GAP     = 3'd2,
        START   = 3'd3,
        RELEASE = 3'd4
    } seq_state_t;

    // Extended bit is not part of the lookup; unknown codes map to KEY_NONE.
    function automatic logic [KEY_IDX_W-1:0] key_index(input logic [7:0] code);
        case (code)
            SC_UP:     key_index = 5'(KEY_UP);
            SC_DOWN:   key_index = 5'(KEY_DOWN);
            SC_LEFT:   key_index = 5'(KEY_LEFT);
            SC_RIGHT:  key_index = 5'(KEY_RIGHT);
            SC_LSHIFT: key_index = 5'(KEY_LSHIFT);
            SC_RSHIFT: key_index = 5'(KEY_RSHIFT);
            SC_SPACE:  key_index = 5'(KEY_SPACE);
            SC_F1:     key_index = 5'(KEY_F1);
            SC_F2:     key_index = 5'(KEY_F2);
            SC_CTRL:   key_index = 5'(KEY_CTRL);
            SC_W:      key_index = 5'(KEY_W);
            SC_A:      key_index = 5'(KEY_A);
            SC_U:      key_index = 5'(KEY_U);
            SC_H:      key_index = 5'(KEY_H);
            SC_1:      key_index = 5'(KEY_1);
            SC_2:      key_index = 5'(KEY_2);
            SC_5:      key_index = 5'(KEY_5);
            SC_6:      key_index = 5'(KEY_6);
            default:   key_index = KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/defender_input_ctrl_if.sv
// Input/button bundle between hps_io, the input controller and the core.
interface defender_input_ctrl_if;
    import defender_input_pkg::*;

    logic [10:0]      ps2_key;
    logic [15:0]      joy;
    logic [BTN_W-1:0] btn;
    logic             seq_busy;

    modport master (output ps2_key, output joy, input btn, input seq_busy);
    modport slave  (input ps2_key, input joy, output btn, output seq_busy);
endinterface

// File: rtl/defender_coin_seq.sv
// Coin/start sequencer: one rising edge of seq_req yields a timed coin pulse,
// a gap, then a timed one-player start pulse.
module defender_coin_seq
    import defender_input_pkg::*;
#(
    parameter int COIN_CYCLES  = 2400000,
    parameter int GAP_CYCLES   = 2400000,
    parameter int START_CYCLES = 2400000,
    parameter int CNT_W        = 24
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic seq_req,
    output logic seq_coin,
    output logic seq_start,
    output logic seq_busy
);
    localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t       r_state, w_next_state;
    logic [CNT_W-1:0] r_timer, w_next_timer;
    logic             r_req_d, w_req_rise;
    logic             r_coin, r_start, r_busy;

    assign w_req_rise = seq_req & ~r_req_d;

    // State, timer and outputs; outputs follow the next state so they align with it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= CNT_ZERO;
            r_req_d <= 1'b0;
            r_coin  <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
            r_req_d <= seq_req;
            r_coin  <= (w_next_state == COIN);
            r_start <= (w_next_state == START);
            r_busy  <= (w_next_state != IDLE);
        end
    end

    // Next-state and timer logic.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        case (r_state)
            IDLE: begin
                if (w_req_rise) begin
                    w_next_state = COIN;
                    w_next_timer = COIN_LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            COIN: begin
                if (r_timer == CNT_ZERO) begin
                    w_next_state = GAP;
                    w_next_timer = GAP_LOAD;
                end else begin
                    w_next_timer = r_timer - CNT_ONE;
                end
            end
            GAP: begin
                if (r_timer == CNT_ZERO) begin
                    w_next_state = START;
                    w_next_timer = START_LOAD;
                end else begin
                    w_next_timer = r_timer - CNT_ONE;
                end
            end
            START: begin
                if (r_timer == CNT_ZERO) begin
                    w_next_state = RELEASE;
                end else begin
                    w_next_timer = r_timer - CNT_ONE;
                end
            end
            RELEASE: begin
                if (!seq_req) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RELEASE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_timer = CNT_ZERO;
            end
        endcase
    end

    assign seq_coin  = r_coin;
    assign seq_start = r_start;
    assign seq_busy  = r_busy;
endmodule

// File: rtl/defender_input_ctrl.sv
// Defender input controller: PS/2 held-key decode, joystick merge and
// registered button vector, with the coin/start sequencer attached.
module defender_input_ctrl
    import defender_input_pkg::*;
#(
    parameter int COIN_CYCLES  = 2400000,
    parameter int GAP_CYCLES   = 2400000,
    parameter int START_CYCLES = 2400000,
    parameter int CNT_W        = 24
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    defender_input_ctrl_if.slave  bus
);
    logic                 r_old_toggle;
    logic                 r_armed;
    logic [NUM_KEYS-1:0]  r_keys;
    logic [BTN_W-1:0]     r_btn, w_btn;
    logic [KEY_IDX_W-1:0] w_key_idx;
    logic                 w_event, w_seq_req, w_seq_coin, w_seq_start, w_seq_busy;
    logic                 w_unused_bits;

    // r_armed keeps the first cycle after reset from seeing a stale toggle.
    assign w_event       = r_armed & (bus.ps2_key[10] ^ r_old_toggle);
    assign w_key_idx     = key_index(bus.ps2_key[7:0]);
    assign w_seq_req     = r_keys[KEY_F1] | bus.joy[8];
    assign w_unused_bits = &{1'b0, bus.ps2_key[8], bus.joy[15:9]};

    // Toggle tracking and per-key held state.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_old_toggle <= 1'b0;
            r_armed      <= 1'b0;
            r_keys       <= {NUM_KEYS{1'b0}};
        end else begin
            r_old_toggle <= bus.ps2_key[10];
            r_armed      <= 1'b1;
            if (w_event && (w_key_idx != KEY_NONE)) begin
                r_keys[w_key_idx] <= bus.ps2_key[9];
            end
        end
    end

    // Button merge of keys, joystick and sequencer pulses.
    always_comb begin
        w_btn                  = {BTN_W{1'b0}};
        w_btn[BTN_THRUST]      = r_keys[KEY_LEFT] | r_keys[KEY_RIGHT] | bus.joy[0] | bus.joy[1];
        w_btn[BTN_REVERSE]     = r_keys[KEY_LSHIFT] | r_keys[KEY_RSHIFT] | bus.joy[4];
        w_btn[BTN_FIRE]        = r_keys[KEY_SPACE] | bus.joy[5];
        w_btn[BTN_SMART_BOMB]  = r_keys[KEY_CTRL] | bus.joy[6];
        w_btn[BTN_HYPERSPACE]  = r_keys[KEY_W] | bus.joy[7];
        w_btn[BTN_DOWN]        = r_keys[KEY_DOWN] | bus.joy[2];
        w_btn[BTN_UP]          = r_keys[KEY_UP] | bus.joy[3];
        w_btn[BTN_ADVANCE]     = r_keys[KEY_A];
        w_btn[BTN_AUTO_UP]     = r_keys[KEY_U];
        w_btn[BTN_HS_RESET]    = r_keys[KEY_H];
        w_btn[BTN_TWO_PLAYERS] = r_keys[KEY_F2] | r_keys[KEY_2];
        w_btn[BTN_COIN]        = r_keys[KEY_5] | r_keys[KEY_6] | w_seq_coin;
        w_btn[BTN_ONE_PLAYER]  = r_keys[KEY_1] | w_seq_start;
    end

    // Registered button vector to the core.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_btn <= {BTN_W{1'b0}};
        end else begin
            r_btn <= w_btn;
        end
    end

    defender_coin_seq #(
        .COIN_CYCLES  (COIN_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .START_CYCLES (START_CYCLES),
        .CNT_W        (CNT_W)
    ) u_coin_seq (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .seq_req   (w_seq_req),
        .seq_coin  (w_seq_coin),
        .seq_start (w_seq_start),
        .seq_busy  (w_seq_busy)
    );

    assign bus.btn      = r_btn;
    assign bus.seq_busy = w_seq_busy;
endmodule

// File: tb/tb_defender_input_ctrl.sv
// Self-checking bench for defender_input_ctrl with short sequencer timings.
module tb_defender_input_ctrl;
    import defender_input_pkg::*;

    localparam int TB_COIN_N  = 8;
    localparam int TB_GAP_N   = 4;
    localparam int TB_START_N = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [255:0] m_held = '0;
    logic [7:0]   codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h59, 8'h29, 8'h06,
                                 8'h14, 8'h1D, 8'h1C, 8'h3C, 8'h33, 8'h16, 8'h1E, 8'h2E,
                                 8'h36, 8'hFF, 8'h11, 8'h15};

    always #5 clk = ~clk;

    defender_input_ctrl_if bus ();

    defender_input_ctrl #(
        .COIN_CYCLES  (TB_COIN_N),
        .GAP_CYCLES   (TB_GAP_N),
        .START_CYCLES (TB_START_N),
        .CNT_W        (24)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [8:0] code, input logic pressed);
        bus.ps2_key = {~bus.ps2_key[10], pressed, code};
    endtask

    task automatic capture(input int n, output logic [127:0] c, output logic [127:0] s,
                           output logic [127:0] b);
        c = '0; s = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            tick;
            c[i] = bus.btn[BTN_COIN];
            s[i] = bus.btn[BTN_ONE_PLAYER];
            b[i] = bus.seq_busy;
        end
    endtask

    function automatic int rises(input logic [127:0] v, input int n);
        int r = 0;
        for (int i = 0; i < n; i++) if (v[i] && (i == 0 || !v[i-1])) r++;
        return r;
    endfunction

    function automatic int first_one(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int run_len(input logic [127:0] v, input int st, input int n);
        int r = 0;
        if (st < 0) return 0;
        for (int i = st; i < n && v[i]; i++) r++;
        return r;
    endfunction

    // Expected buttons from the held-key set (by scancode) and joystick bits.
    function automatic logic [12:0] model_btn(input logic [255:0] h, input logic [15:0] j);
        logic [12:0] b = 13'd0;
        b[BTN_THRUST]      = h[8'h6B] | h[8'h74] | j[0] | j[1];
        b[BTN_REVERSE]     = h[8'h12] | h[8'h59] | j[4];
        b[BTN_FIRE]        = h[8'h29] | j[5];
        b[BTN_SMART_BOMB]  = h[8'h14] | j[6];
        b[BTN_HYPERSPACE]  = h[8'h1D] | j[7];
        b[BTN_DOWN]        = h[8'h72] | j[2];
        b[BTN_UP]          = h[8'h75] | j[3];
        b[BTN_ADVANCE]     = h[8'h1C];
        b[BTN_AUTO_UP]     = h[8'h3C];
        b[BTN_HS_RESET]    = h[8'h33];
        b[BTN_TWO_PLAYERS] = h[8'h06] | h[8'h1E];
        b[BTN_COIN]        = h[8'h2E] | h[8'h36];
        b[BTN_ONE_PLAYER]  = h[8'h16];
        return b;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.ps2_key = 11'd0;
        bus.joy = 16'd0;
        repeat (3) tick;
        n_total++;
        if (bus.btn !== 13'd0) $display("FAIL reset_btn: got %0h want 0", bus.btn); else n_pass++;
        n_total++;
        if (bus.seq_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.seq_busy); else n_pass++;
        rst = 1'b0;
        repeat (2) tick;
        n_total++;
        if (bus.btn !== 13'd0) $display("FAIL post_reset_btn: got %0h want 0", bus.btn); else n_pass++;
    endtask

    task automatic test_fire_key;
        send_key(9'h029, 1'b1);
        tick;
        n_total++;
        if (bus.btn[BTN_FIRE] !== 1'b0) $display("FAIL fire_lat1: got %0b want 0", bus.btn[BTN_FIRE]); else n_pass++;
        tick;
        n_total++;
        if (bus.btn[BTN_FIRE] !== 1'b1) $display("FAIL fire_press: got %0b want 1", bus.btn[BTN_FIRE]); else n_pass++;
        send_key(9'h029, 1'b0);
        tick;
        n_total++;
        if (bus.btn[BTN_FIRE] !== 1'b1) $display("FAIL fire_rel_lat1: got %0b want 1", bus.btn[BTN_FIRE]); else n_pass++;
        tick;
        n_total++;
        if (bus.btn[BTN_FIRE] !== 1'b0) $display("FAIL fire_release: got %0b want 0", bus.btn[BTN_FIRE]); else n_pass++;
    endtask

    task automatic test_shared_thrust;
        send_key(9'h16B, 1'b1); repeat (2) tick;
        send_key(9'h174, 1'b1); repeat (2) tick;
        n_total++;
        if (bus.btn[BTN_THRUST] !== 1'b1) $display("FAIL thrust_both: got %0b want 1", bus.btn[BTN_THRUST]); else n_pass++;
        send_key(9'h16B, 1'b0); repeat (3) tick;
        n_total++;
        if (bus.btn[BTN_THRUST] !== 1'b1) $display("FAIL thrust_one_left: got %0b want 1", bus.btn[BTN_THRUST]); else n_pass++;
        send_key(9'h174, 1'b0); repeat (2) tick;
        n_total++;
        if (bus.btn[BTN_THRUST] !== 1'b0) $display("FAIL thrust_none: got %0b want 0", bus.btn[BTN_THRUST]); else n_pass++;
    endtask

    task automatic check_full_seq(input logic [127:0] c, input logic [127:0] s, input int n);
        int cr = first_one(c, n);
        int sr = first_one(s, n);
        int cl = run_len(c, cr, n);
        n_total++;
        if (rises(c, n) !== 1) $display("FAIL seq_coin_count: got %0d want 1", rises(c, n)); else n_pass++;
        n_total++;
        if (cl !== TB_COIN_N) $display("FAIL seq_coin_len: got %0d want %0d", cl, TB_COIN_N); else n_pass++;
        n_total++;
        if (cr < 0 || sr - (cr + cl) !== TB_GAP_N)
            $display("FAIL seq_gap_len: got %0d want %0d", sr - (cr + cl), TB_GAP_N);
        else n_pass++;
        n_total++;
        if (rises(s, n) !== 1) $display("FAIL seq_start_count: got %0d want 1", rises(s, n)); else n_pass++;
        n_total++;
        if (run_len(s, sr, n) !== TB_START_N)
            $display("FAIL seq_start_len: got %0d want %0d", run_len(s, sr, n), TB_START_N);
        else n_pass++;
    endtask

    task automatic test_sequence;
        logic [127:0] c, s, b;
        bus.joy = 16'h0100;
        capture(60, c, s, b);
        check_full_seq(c, s, 60);
        n_total++;
        if (b[59] !== 1'b1) $display("FAIL seq_busy_held: got %0b want 1", b[59]); else n_pass++;
        bus.joy = 16'h0000;
        repeat (2) tick;
        n_total++;
        if (bus.seq_busy !== 1'b0) $display("FAIL seq_busy_drop: got %0b want 0", bus.seq_busy); else n_pass++;
    endtask

    task automatic test_f1_in_gap;
        logic [127:0] c, s, b;
        bit seen_hi = 1'b0;
        bit in_gap  = 1'b0;
        bus.joy = 16'h0100;
        repeat (2) tick;
        bus.joy = 16'h0000;
        for (int i = 0; i < 30 && !in_gap; i++) begin
            tick;
            if (bus.btn[BTN_COIN]) seen_hi = 1'b1;
            else if (seen_hi) in_gap = 1'b1;
        end
        n_total++;
        if (!in_gap) $display("FAIL f1_reach_gap: got %0b want 1", in_gap); else n_pass++;
        send_key(9'h005, 1'b1);
        tick;
        send_key(9'h005, 1'b0);
        capture(40, c, s, b);
        n_total++;
        if (1 + rises(c, 40) !== 1) $display("FAIL f1_coin_total: got %0d want 1", 1 + rises(c, 40)); else n_pass++;
        n_total++;
        if (rises(s, 40) !== 1) $display("FAIL f1_start_total: got %0d want 1", rises(s, 40)); else n_pass++;
        n_total++;
        if (b[39] !== 1'b0) $display("FAIL f1_idle_after: got %0b want 0", b[39]); else n_pass++;
    endtask

    task automatic test_reset_in_start;
        logic [127:0] c, s, b;
        bit found = 1'b0;
        bus.joy = 16'h0100;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (bus.btn[BTN_ONE_PLAYER]) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL rst_reach_start: got %0b want 1", found); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.btn !== 13'd0) $display("FAIL rst_async_btn: got %0h want 0", bus.btn); else n_pass++;
        n_total++;
        if (bus.seq_busy !== 1'b0) $display("FAIL rst_async_busy: got %0b want 0", bus.seq_busy); else n_pass++;
        bus.joy = 16'h0000;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        bus.joy = 16'h0100;
        capture(60, c, s, b);
        check_full_seq(c, s, 60);
        bus.joy = 16'h0000;
        repeat (2) tick;
    endtask

    task automatic test_toggle_at_release;
        rst = 1'b1;
        bus.ps2_key = 11'd0;
        repeat (2) tick;
        rst = 1'b0;
        bus.ps2_key = {1'b1, 1'b1, 9'h0FF};
        for (int i = 0; i < 4; i++) begin
            tick;
            n_total++;
            if (bus.btn !== 13'd0) $display("FAIL rel_toggle_ff: got %0h want 0", bus.btn); else n_pass++;
        end
        rst = 1'b1;
        bus.ps2_key = {1'b1, 1'b1, 9'h029};
        repeat (2) tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_total++;
            if (bus.btn !== 13'd0) $display("FAIL rel_stale_toggle: got %0h want 0", bus.btn); else n_pass++;
        end
    endtask

    task automatic test_random_keys;
        logic [12:0] exp_btn = 13'd0;
        logic [15:0] j;
        logic [7:0]  code;
        logic        pr;
        bit          have_exp = 1'b0;
        m_held = '0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (have_exp) begin
                n_total++;
                if (bus.btn !== exp_btn)
                    $display("FAIL random_btn[%0d]: got %0h want %0h", i, bus.btn, exp_btn);
                else n_pass++;
            end
            j = {8'd0, 8'($urandom)};
            bus.joy = j;
            exp_btn = model_btn(m_held, j);
            have_exp = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                code = codes[$urandom_range(0, 19)];
                pr = 1'($urandom_range(0, 1));
                send_key({1'($urandom_range(0, 1)), code}, pr);
                m_held[code] = pr;
            end
        end
        bus.joy = 16'h0000;
    endtask

    initial begin
        bus.ps2_key = 11'd0;
        bus.joy = 16'd0;
        test_reset;
        test_fire_key;
        test_shared_thrust;
        test_sequence;
        test_f1_in_gap;
        test_reset_in_start;
        test_toggle_at_release;
        test_random_keys;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
